// File: rtl/logic_gates_stim_seq_if.sv
// Purpose: bundles the stimulus sequencer's control, gate-feedback and status signals.
// Latency: none, wiring only.
// Backpressure: none; iPause is the only flow control and is a level, not a handshake.
interface logic_gates_stim_seq_if;
    logic       iStart;
    logic       iPause;
    logic       iAnd;
    logic       iOr;
    logic       iNot;
    logic       oA;
    logic       oB;
    logic       oValid;
    logic       oBusy;
    logic       oDone;
    logic [1:0] oVecIdx;
    logic [7:0] oLoop;
    logic [7:0] oErrCnt;

    // Sequencer side: takes requests and gate feedback, drives vectors and status.
    modport master (
        input  iStart, iPause, iAnd, iOr, iNot,
        output oA, oB, oValid, oBusy, oDone, oVecIdx, oLoop, oErrCnt
    );

    // Controller / gate-block side.
    modport slave (
        output iStart, iPause, iAnd, iOr, iNot,
        input  oA, oB, oValid, oBusy, oDone, oVecIdx, oLoop, oErrCnt
    );
endinterface

// File: rtl/logic_gates_stim_seq.sv
// Purpose: steps (A,B) through 00,10,01,11 for LOOPS passes, DWELL cycles per vector, then parks at 00.
// Latency: the first vector appears on the same edge that samples iStart; every output is registered.
// Backpressure: iPause freezes counter, vector and pass count while running; iStart is ignored while running.
// Option: define LOGIC_GATES_STIM_CHECK_EN to compare gate feedback on each vector's last dwell cycle.
module logic_gates_stim_seq #(
    parameter int DWELL = 40,
    parameter int LOOPS = 1,
    parameter int CNT_W = 16
) (
    input  logic                     iClk,
    input  logic                     iRst,
    logic_gates_stim_seq_if.master   bus
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [7:0]       LOOPS_LAST = 8'(LOOPS - 1);

    state_t           state, stateNxt;
    logic [CNT_W-1:0] cnt, cntNxt;
    logic [1:0]       idx, idxNxt, idxInc;
    logic [7:0]       loopCnt, loopNxt;
    logic [7:0]       errCnt, errNxt;
    logic             aReg, aNxt, bReg, bNxt;
    logic             validReg, validNxt, busyReg, busyNxt, doneReg, doneNxt;
    logic             startReq, stepEnd, lastStep, mismatch;

    assign startReq = (state != RUN) && bus.iStart;
    assign stepEnd  = (state == RUN) && !bus.iPause && (cnt == DWELL_LAST);
    assign lastStep = stepEnd && (idx == 2'd3) && (loopCnt == LOOPS_LAST);
    assign idxInc   = idx + 2'd1;

`ifdef LOGIC_GATES_STIM_CHECK_EN
    // Feedback is judged against the vector currently on oA/oB, which the gate block has had DWELL cycles to settle on.
    assign mismatch = (bus.iAnd != (aReg & bReg)) ||
                      (bus.iOr  != (aReg | bReg)) ||
                      (bus.iNot != ~aReg);
`else
    logic unusedFeedback;
    assign unusedFeedback = ^{bus.iAnd, bus.iOr, bus.iNot};
    assign mismatch       = 1'b0;
`endif

    // State register; reset wins over everything.
    always_ff @(posedge iClk) begin
        if (iRst) state <= IDLE;
        else      state <= stateNxt;
    end

    // Next-state: start from IDLE/DONE, finish on the last dwell cycle of the last vector of the last pass.
    always_comb begin
        stateNxt = state;
        unique case (state)
            IDLE, DONE: if (bus.iStart) stateNxt = RUN;
            RUN:        if (lastStep)   stateNxt = DONE;
            default:    stateNxt = IDLE;
        endcase
    end

    // Next values for the counter, vector index and every registered output.
    always_comb begin
        cntNxt   = cnt;
        idxNxt   = idx;
        loopNxt  = loopCnt;
        errNxt   = errCnt;
        aNxt     = aReg;
        bNxt     = bReg;
        validNxt = validReg;
        busyNxt  = busyReg;
        doneNxt  = doneReg;
        if (startReq) begin
            cntNxt   = '0;
            idxNxt   = 2'd0;
            loopNxt  = 8'd0;
            errNxt   = 8'd0;
            aNxt     = 1'b0;
            bNxt     = 1'b0;
            validNxt = 1'b1;
            busyNxt  = 1'b1;
            doneNxt  = 1'b0;
        end else if (stepEnd) begin
            cntNxt = '0;
            if (idx == 2'd3) loopNxt = loopCnt + 8'd1;
            if (mismatch && (errCnt != 8'hFF)) errNxt = errCnt + 8'd1;
            if (lastStep) begin
                idxNxt   = 2'd0;
                aNxt     = 1'b0;
                bNxt     = 1'b0;
                validNxt = 1'b0;
                busyNxt  = 1'b0;
                doneNxt  = 1'b1;
            end else begin
                // Index bit 0 is A and bit 1 is B, giving the 00,10,01,11 order.
                idxNxt = idxInc;
                aNxt   = idxInc[0];
                bNxt   = idxInc[1];
            end
        end else if ((state == RUN) && !bus.iPause) begin
            cntNxt = cnt + 1'b1;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            cnt      <= '0;
            idx      <= 2'd0;
            loopCnt  <= 8'd0;
            errCnt   <= 8'd0;
            aReg     <= 1'b0;
            bReg     <= 1'b0;
            validReg <= 1'b0;
            busyReg  <= 1'b0;
            doneReg  <= 1'b0;
        end else begin
            cnt      <= cntNxt;
            idx      <= idxNxt;
            loopCnt  <= loopNxt;
            errCnt   <= errNxt;
            aReg     <= aNxt;
            bReg     <= bNxt;
            validReg <= validNxt;
            busyReg  <= busyNxt;
            doneReg  <= doneNxt;
        end
    end

    assign bus.oA      = aReg;
    assign bus.oB      = bReg;
    assign bus.oValid  = validReg;
    assign bus.oBusy   = busyReg;
    assign bus.oDone   = doneReg;
    assign bus.oVecIdx = idx;
    assign bus.oLoop   = loopCnt;
    assign bus.oErrCnt = errCnt;

endmodule

// File: tb/tb_logic_gates_stim_seq.sv
module tb_logic_gates_stim_seq;

    typedef struct {
        int off;
        bit start;
        bit pause;
        bit a;
        bit b;
        bit valid;
        bit busy;
        bit done;
        int idx;
        int loop;
        int err;
    } vec_t;

`ifdef LOGIC_GATES_STIM_CHECK_EN
    localparam int ERR2 = 6;
`else
    localparam int ERR2 = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, rst2;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic_gates_stim_seq_if bus1 ();
    logic_gates_stim_seq_if bus2 ();

    // Ideal gate block on DUT1; DUT2 sees a gate block whose NOT output is stuck low.
    assign bus1.iAnd = bus1.oA & bus1.oB;
    assign bus1.iOr  = bus1.oA | bus1.oB;
    assign bus1.iNot = ~bus1.oA;
    assign bus2.iAnd = bus2.oA & bus2.oB;
    assign bus2.iOr  = bus2.oA | bus2.oB;
    assign bus2.iNot = 1'b0;

    logic_gates_stim_seq #(.DWELL(40), .LOOPS(1), .CNT_W(16)) dut1 (
        .iClk (clk),
        .iRst (rst1),
        .bus  (bus1.master)
    );

    logic_gates_stim_seq #(.DWELL(1), .LOOPS(3), .CNT_W(16)) dut2 (
        .iClk (clk),
        .iRst (rst2),
        .bus  (bus2.master)
    );

    function automatic vec_t mk(input int off, input bit st, input bit pa,
                                input bit a, input bit b, input bit v, input bit bz, input bit d,
                                input int idx, input int loop, input int err);
        vec_t r;
        r.off = off; r.start = st; r.pause = pa;
        r.a = a; r.b = b; r.valid = v; r.busy = bz; r.done = d;
        r.idx = idx; r.loop = loop; r.err = err;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickTo(input int t);
        while (cyc < t) tick();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chkOut(input string tag, input vec_t e,
                          input logic a, input logic b, input logic v, input logic bz, input logic d,
                          input logic [1:0] idx, input logic [7:0] loop, input logic [7:0] err);
        chk({tag, ".oA"},      32'(a),    32'(e.a));
        chk({tag, ".oB"},      32'(b),    32'(e.b));
        chk({tag, ".oValid"},  32'(v),    32'(e.valid));
        chk({tag, ".oBusy"},   32'(bz),   32'(e.busy));
        chk({tag, ".oDone"},   32'(d),    32'(e.done));
        chk({tag, ".oVecIdx"}, 32'(idx),  32'(e.idx));
        chk({tag, ".oLoop"},   32'(loop), 32'(e.loop));
        chk({tag, ".oErrCnt"}, 32'(err),  32'(e.err));
    endtask

    task automatic chk1(input string tag, input vec_t e);
        chkOut(tag, e, bus1.oA, bus1.oB, bus1.oValid, bus1.oBusy, bus1.oDone,
               bus1.oVecIdx, bus1.oLoop, bus1.oErrCnt);
    endtask

    task automatic chk2(input string tag, input vec_t e);
        chkOut(tag, e, bus2.oA, bus2.oB, bus2.oValid, bus2.oBusy, bus2.oDone,
               bus2.oVecIdx, bus2.oLoop, bus2.oErrCnt);
    endtask

    task automatic reset1();
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[11];
        vec_t idleExp;
        vec_t e;
        int   k;

        idleExp = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // DWELL=40, LOOPS=1: offsets are edges after the start edge.
        tbl[0]  = mk(  0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        tbl[1]  = mk( 20, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);   // start while running is ignored
        tbl[2]  = mk( 39, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        tbl[3]  = mk( 40, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0);
        tbl[4]  = mk( 80, 0, 0, 0, 1, 1, 1, 0, 2, 0, 0);
        tbl[5]  = mk(120, 0, 0, 1, 1, 1, 1, 0, 3, 0, 0);
        tbl[6]  = mk(159, 0, 0, 1, 1, 1, 1, 0, 3, 0, 0);
        tbl[7]  = mk(160, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        tbl[8]  = mk(165, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        tbl[9]  = mk(166, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0);   // pause has no effect in DONE
        tbl[10] = mk(170, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);   // restart from DONE

        rst1 = 1'b1;
        rst2 = 1'b1;
        bus1.iStart = 1'b0; bus1.iPause = 1'b0;
        bus2.iStart = 1'b0; bus2.iPause = 1'b0;
        tick();
        tick();
        chk1("reset1", idleExp);
        chk2("reset2", idleExp);
        rst1 = 1'b0;
        rst2 = 1'b0;

        // Pause in IDLE does nothing.
        bus1.iPause = 1'b1;
        tick();
        bus1.iPause = 1'b0;
        chk1("idlePause", idleExp);

        // Table-driven nominal run.
        k = cyc + 10;
        for (int i = 0; i < 11; i++) begin
            tickTo(k + tbl[i].off - 1);
            bus1.iStart = tbl[i].start;
            bus1.iPause = tbl[i].pause;
            tick();
            bus1.iStart = 1'b0;
            bus1.iPause = 1'b0;
            chk1($sformatf("tbl%0d", i), tbl[i]);
        end
        reset1();
        chk1("resetAfterTbl", idleExp);

        // DWELL=1, LOOPS=3: new vector every edge, done 12 edges after start.
        k = cyc + 2;
        tickTo(k - 1);
        bus2.iStart = 1'b1;
        tick();
        bus2.iStart = 1'b0;
        for (int j = 0; j < 12; j++) begin
            chk($sformatf("d1.idx%0d", j),  32'(bus2.oVecIdx), 32'(j % 4));
            chk($sformatf("d1.a%0d", j),    32'(bus2.oA),      32'((j % 4) & 1));
            chk($sformatf("d1.b%0d", j),    32'(bus2.oB),      32'((j % 4) >> 1));
            chk($sformatf("d1.loop%0d", j), 32'(bus2.oLoop),   32'(j / 4));
            chk($sformatf("d1.vld%0d", j),  32'(bus2.oValid),  32'd1);
            tick();
        end
        chk2("d1.done", mk(12, 0, 0, 0, 0, 0, 0, 1, 0, 3, ERR2));

        // Pause for 7 edges inside idx2 stretches it to 47 cycles and delays done by 7.
        k = cyc + 2;
        tickTo(k - 1);
        bus1.iStart = 1'b1;
        tick();
        bus1.iStart = 1'b0;
        tickTo(k + 80);
        e = mk(0, 0, 0, 0, 1, 1, 1, 0, 2, 0, 0);
        chk1("p.idx2Start", e);
        tickTo(k + 89);
        bus1.iPause = 1'b1;
        for (int j = 0; j < 7; j++) begin
            tick();
            chk1($sformatf("p.hold%0d", j), e);
        end
        bus1.iPause = 1'b0;
        tickTo(k + 126);
        chk1("p.idx2End", e);
        tick();
        chk1("p.idx3", mk(0, 0, 0, 1, 1, 1, 1, 0, 3, 0, 0));
        tickTo(k + 166);
        chk1("p.lastRun", mk(0, 0, 0, 1, 1, 1, 1, 0, 3, 0, 0));
        tick();
        chk1("p.done", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));

        // Reset mid-run wins even over a simultaneous start; then restart with start+pause.
        reset1();
        k = cyc + 2;
        tickTo(k - 1);
        bus1.iStart = 1'b1;
        tick();
        bus1.iStart = 1'b0;
        tickTo(k + 74);
        chk1("r.beforeRst", mk(0, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0));
        rst1 = 1'b1;
        bus1.iStart = 1'b1;
        tick();
        rst1 = 1'b0;
        bus1.iStart = 1'b0;
        chk1("r.afterRst", idleExp);
        tickTo(k + 79);
        bus1.iStart = 1'b1;
        bus1.iPause = 1'b1;
        tick();
        bus1.iStart = 1'b0;
        e = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        chk1("r.restart", e);
        tickTo(k + 85);
        bus1.iPause = 1'b0;
        chk1("r.paused", e);
        tickTo(k + 124);
        chk1("r.idx0End", e);
        tick();
        chk1("r.idx1", mk(0, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logic_gates_stim_seq.md
Name: logic_gates_stim_seq

Overview:
- Synthesizable stimulus sequencer directly upstream of logic_gates_3. It drives the gate block's iA/iB inputs.
- Steps through the four 2-input vectors in fixed order (A,B) = 00, 10, 01, 11. Each vector is held for a programmable dwell, for a programmable number of passes, then the sequencer parks at 00.
- Replaces the hand-written delay stimulus so the gate block can be exercised on the board from a push-button.

Parameters:
- DWELL, 40, clock cycles each vector is held; legal range 1..2^CNT_W-1.
- LOOPS, 1, number of complete passes through the 4 vectors; legal range 1..255.
- CNT_W, 16, width of the dwell counter.

Ports:
- iClk  input  1  system clock, rising-edge.
- iRst  input  1  synchronous, active-high reset.
- iStart  input  1  start request; sampled only in IDLE or DONE.
- iPause  input  1  level; freezes the sequence while high in RUN.
- iAnd  input  1  oAnd fed back from logic_gates_3 (used only with CHECK_EN).
- iOr  input  1  oOr fed back from logic_gates_3 (used only with CHECK_EN).
- iNot  input  1  oNot fed back from logic_gates_3 (used only with CHECK_EN).
- oA  output  1  drives logic_gates_3 iA.
- oB  output  1  drives logic_gates_3 iB.
- oValid  output  1  high while a vector is being driven (RUN state).
- oBusy  output  1  high in RUN, including while paused.
- oDone  output  1  high in DONE until the next iStart or reset.
- oVecIdx  output  2  index 0..3 of the current vector.
- oLoop  output  8  completed-pass count.
- oErrCnt  output  8  saturating mismatch count (CHECK_EN only).

Behaviour:
- All outputs are registered.
- Reset (iRst=1 at a rising edge): state IDLE; oA=0, oB=0, oValid=0, oBusy=0, oDone=0, oVecIdx=0, oLoop=0, oErrCnt=0; dwell counter=0.
- Reset mid-RUN aborts the pass and returns to IDLE at that same edge. Reset has priority over every other input.
- States are IDLE, RUN and DONE.
- IDLE/DONE -> RUN: iStart=1 at edge k.
  - At edge k: state=RUN, oVecIdx=0, oA=0, oB=0, oValid=1, oBusy=1, oDone=0, oLoop=0, counter=0, oErrCnt cleared.
- RUN vector mapping: idx0=00, idx1=10, idx2=01, idx3=11, as (oA,oB).
- RUN counting: while iPause=0 the counter increments each edge.
  - When counter==DWELL-1, the next edge sets counter=0 and idx=idx+1.
  - When idx wraps from 3 to 0, oLoop increments.
- Vector n of pass p is first driven at edge k + (4p+n)*DWELL and held exactly DWELL cycles.
- RUN -> DONE: at edge k + 4*LOOPS*DWELL. At that edge oA=0, oB=0, oValid=0, oBusy=0, oDone=1, oLoop=LOOPS, oVecIdx=0.
- iPause=1 in RUN: counter, idx, oA, oB and oLoop all hold; oValid and oBusy stay 1. Each paused cycle extends the run by one cycle.
- iPause has no effect in IDLE or DONE. iStart together with iPause in IDLE is honoured: the sequence starts, and the pause applies from the next cycle.
- iStart during RUN is ignored. iStart in DONE restarts exactly as from IDLE.
- DWELL=1: the vector changes every cycle; a pass is 4 cycles.

Optional Feature:
- Macro: LOGIC_GATES_STIM_CHECK_EN.
- Defined: on the last dwell cycle of each vector (counter==DWELL-1, iPause=0), the block compares iAnd against oA&oB, iOr against oA|oB, and iNot against ~oA.
  - Any mismatch increments oErrCnt by 1 (one increment per vector, however many bits differ), saturating at 255.
  - oErrCnt is cleared on reset and on iStart.
- Not defined: iAnd, iOr and iNot are ignored, and oErrCnt is constant 0. Port list is unchanged.

Test Plan:
- Reset, DWELL=40, LOOPS=1, iStart pulse at cycle 10:
  - oA/oB = 00, 10, 01, 11 at cycles 10, 50, 90, 130.
  - oDone=1 and oA=oB=0 at cycle 170; oLoop=1.
- DWELL=1, LOOPS=3: vectors change every cycle; oDone at start+12; oLoop=3.
- iPause high for 7 cycles during idx2: idx2 is held 47 cycles; oDone is 7 cycles later than nominal; oBusy stays 1 throughout.
- iRst asserted at start+75: next edge gives IDLE with all outputs 0. iStart at start+80 restarts from idx0.
- iStart during RUN at start+20: no effect on timing. iStart in DONE: a new run with oDone=0 and oLoop=0.
- CHECK_EN with logic_gates_3 attached: oErrCnt=0 after the run. With iNot forced to 0: oErrCnt=2 per pass (idx0, idx2), i.e. 6 when LOOPS=3.
